countdown_timer_nbit: RTL and testbench
=======================================

Name: countdown_timer_nbit

Overview:
- Loadable N-bit down-counter with an FSM-based start/pause/resume control, a clock prescaler and a one-cycle terminal-count pulse.
- Counterpart to the team's free-running up-counter. Used as the timing source for display multiplexing, debounce windows and stopwatch/alarm labs.
- Counts a loaded value down to zero, then either stops or auto-reloads.

Parameters:
- N, 8, counter width in bits (N >= 2).
- PRESCALE, 4, clk cycles per decrement tick (PRESCALE >= 1; 1 = decrement every cycle).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- load  input  1  load load_value into count and reload register.
- load_value  input  N  value captured on load.
- start  input  1  start from IDLE / resume from PAUSE.
- pause  input  1  freeze countdown while in RUN.
- auto_reload  input  1  sampled at terminal count; 1 = reload and keep running.
- count  output  N  current counter value (registered).
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle registered pulse at terminal count.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: count=0, reload_reg=0, prescaler=0, state=IDLE, busy=0, done=0. Reset overrides every other input, including mid-count.
- States: IDLE, RUN, PAUSE. busy is a registered decode of RUN|PAUSE and is valid the cycle after the transition.
- Input priority each cycle: reset > load > pause > start.
- load, in any state:
  - count<=load_value, reload_reg<=load_value, prescaler<=0, state<=IDLE, done<=0.
  - A running countdown is aborted.
- IDLE + start:
  - count!=0: state<=RUN, prescaler<=0.
  - count==0: stay IDLE, done pulses 1 cycle (terminal already reached).
- RUN:
  - prescaler increments each cycle.
  - When prescaler==PRESCALE-1 (tick): prescaler<=0, count decrements.
  - First decrement occurs PRESCALE cycles after the RUN-entry edge.
- Terminal count (tick while count==1):
  - auto_reload=0: count<=0, state<=IDLE.
  - auto_reload=1: count<=reload_reg, state stays RUN, prescaler<=0.
  - Either case: done=1 in the same cycle count shows the new value, for exactly 1 cycle.
- RUN + pause:
  - state<=PAUSE; prescaler and count hold.
  - pause wins over a coinciding tick: no decrement that cycle.
- PAUSE + start: state<=RUN; prescaler resumes from its held value, so there is no extra delay.
- Ignored inputs: start in RUN; pause in IDLE or PAUSE.
- start and pause together: pause wins in RUN; start wins in PAUSE (resume); start acts alone in IDLE.
- No wrap-around: count never decrements below 0 and never wraps to 2^N-1.
- done is low in all cycles not listed above.

Test Plan:
- Reset is held 2 cycles, then released with no other inputs -> count=0, busy=0, done=0, and they stay there for 20 cycles.
- load_value=3, load; start; PRESCALE=4 -> count 3→2→1→0 at 4-cycle spacing; done=1 only in the cycle count becomes 0; then state is IDLE and busy=0.
- load_value=2, auto_reload=1, start -> count sequence 2,1,2,1,2…; done pulses every 8 cycles; busy stays 1.
- load_value=5, start; pause asserted for 10 cycles right after the first decrement (count=4); then start -> count holds 4 during the pause; the next decrement comes after the remaining prescaler cycles; total run time is 20 cycles plus the paused cycles.
- load_value=0, start -> done pulses 1 cycle, busy stays 0, count stays 0.
- Mid-run at count=6 of load_value=9: assert load with load_value=0x80 -> count=0x80, IDLE, no done pulse. Separately, assert reset at count=6 -> count=0 and IDLE on the next edge.

Source files
------------

// File: rtl/countdown_timer_nbit.sv
// Loadable N-bit down-counter with IDLE/RUN/PAUSE control, a clock prescaler
// and a one-cycle registered done pulse at terminal count.
module countdown_timer_nbit #(
    parameter int N        = 8,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [N-1:0]    count_reg;
    logic [N-1:0]    reload_reg;
    logic [PW-1:0]   prescale_reg;
    logic            busy_reg;
    logic            done_reg;

    // busy is updated alongside every state change so it tracks RUN|PAUSE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            reload_reg   <= '0;
            prescale_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                count_reg    <= load_value;
                reload_reg   <= load_value;
                prescale_reg <= '0;
                state_reg    <= IDLE;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (count_reg != '0) begin
                                state_reg    <= RUN;
                                busy_reg     <= 1'b1;
                                prescale_reg <= '0;
                            end else begin
                                done_reg <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state_reg <= PAUSE;
                        end else if (count_reg == '0) begin
                            // Unreachable guard: never decrement through zero.
                            state_reg    <= IDLE;
                            busy_reg     <= 1'b0;
                            prescale_reg <= '0;
                        end else if (prescale_reg == PS_LAST) begin
                            prescale_reg <= '0;
                            if (count_reg == N'(1)) begin
                                done_reg <= 1'b1;
                                if (auto_reload) begin
                                    count_reg <= reload_reg;
                                end else begin
                                    count_reg <= '0;
                                    state_reg <= IDLE;
                                    busy_reg  <= 1'b0;
                                end
                            end else begin
                                count_reg <= count_reg - N'(1);
                            end
                        end else begin
                            prescale_reg <= prescale_reg + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state_reg <= RUN;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_countdown_timer_nbit.sv
// Directed bench for countdown_timer_nbit: a cycle-level behavioural model is
// compared every cycle, plus hand-computed literal checkpoints.
module tb_countdown_timer_nbit;

    localparam int N        = 8;
    localparam int PRESCALE = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [N-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         auto_reload = 1'b0;
    logic [N-1:0] count;
    logic         busy;
    logic         done;

    countdown_timer_nbit #(.N(N), .PRESCALE(PRESCALE)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_value(load_value),
        .start(start),
        .pause(pause),
        .auto_reload(auto_reload),
        .count(count),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Model: running/paused flags, value, reload value, cycles spent in the
    // current tick period.
    typedef struct {
        int cnt;
        int rld;
        int el;
        bit run;
        bit pse;
        bit dn;
    } mdl_t;

    mdl_t m = '{0, 0, 0, 1'b0, 1'b0, 1'b0};

    function automatic mdl_t model_next(mdl_t cur, bit rst, bit ld, bit st,
                                        bit ps, bit ar, int lv);
        mdl_t n;
        n    = cur;
        n.dn = 1'b0;
        if (rst) begin
            n.cnt = 0; n.rld = 0; n.el = 0; n.run = 0; n.pse = 0;
        end else if (ld) begin
            n.cnt = lv; n.rld = lv; n.el = 0; n.run = 0; n.pse = 0;
        end else if (cur.run) begin
            if (ps) begin
                n.run = 0;
                n.pse = 1;
            end else if (cur.el + 1 < PRESCALE) begin
                n.el = cur.el + 1;
            end else begin
                n.el = 0;
                if (cur.cnt > 1) begin
                    n.cnt = cur.cnt - 1;
                end else begin
                    n.dn = 1'b1;
                    if (ar) begin
                        n.cnt = cur.rld;
                    end else begin
                        n.cnt = 0;
                        n.run = 0;
                    end
                end
            end
        end else if (cur.pse) begin
            if (st) begin
                n.run = 1;
                n.pse = 0;
            end
        end else if (st) begin
            if (cur.cnt != 0) begin
                n.run = 1;
                n.el  = 0;
            end else begin
                n.dn = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, reset, load, start, pause, auto_reload, int'(load_value));
    end

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;
    int  cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n cycles; after each edge compare the DUT against the model.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (chk_en) begin
                tests++;
                if (count !== N'(m.cnt) || busy !== (m.run | m.pse) || done !== m.dn) begin
                    fails++;
                    $display("FAIL model cycle %0d: count=%0d busy=%0b done=%0b, expected count=%0d busy=%0b done=%0b",
                             cyc, count, busy, done, m.cnt, m.run | m.pse, m.dn);
                end
            end
        end
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_value = N'(v);
        tick(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset held for two edges, then idle for 20 cycles.
        tick(2);
        chk_en = 1'b1;
        chk("reset count", int'(count), 0);
        chk("reset busy", int'(busy), 0);
        reset = 1'b0;
        tick(20);
        chk("idle count", int'(count), 0);
        chk("idle done", int'(done), 0);
        $display("[TB] reset/idle done");

        // One-shot countdown from 3.
        do_load(3);
        chk("load3 count", int'(count), 3);
        do_start();
        chk("run busy", int'(busy), 1);
        tick(3);
        chk("pre-first-tick count", int'(count), 3);
        tick(1);
        chk("first tick count", int'(count), 2);
        tick(4);
        chk("second tick count", int'(count), 1);
        tick(3);
        chk("before terminal done", int'(done), 0);
        tick(1);
        chk("terminal count", int'(count), 0);
        chk("terminal done", int'(done), 1);
        chk("terminal busy", int'(busy), 0);
        tick(1);
        chk("done one cycle", int'(done), 0);
        $display("[TB] one-shot countdown from 3 done");

        // Auto-reload from 2.
        auto_reload = 1'b1;
        do_load(2);
        do_start();
        tick(4);
        chk("reload first tick", int'(count), 1);
        tick(4);
        chk("reload value", int'(count), 2);
        chk("reload done", int'(done), 1);
        tick(1);
        chk("reload done clears", int'(done), 0);
        tick(7);
        chk("reload second done", int'(done), 1);
        chk("reload busy", int'(busy), 1);
        tick(3);
        do_load(0);
        chk("abort busy", int'(busy), 0);
        auto_reload = 1'b0;
        $display("[TB] auto-reload from 2 done");

        // Pause for 10 cycles after the first decrement of 5.
        do_load(5);
        do_start();
        tick(4);
        chk("pause pre count", int'(count), 4);
        pause = 1'b1;
        tick(10);
        pause = 1'b0;
        chk("paused count", int'(count), 4);
        chk("paused busy", int'(busy), 1);
        do_start();
        tick(3);
        chk("resume hold", int'(count), 4);
        tick(1);
        chk("resume tick", int'(count), 3);
        tick(12);
        chk("pause run end count", int'(count), 0);
        chk("pause run end done", int'(done), 1);
        $display("[TB] pause/resume from 5 done");

        // Start with zero loaded.
        do_load(0);
        do_start();
        chk("zero start done", int'(done), 1);
        chk("zero start busy", int'(busy), 0);
        tick(1);
        chk("zero done clears", int'(done), 0);
        $display("[TB] zero start done");

        // Start+pause together: pause wins in RUN, start wins in PAUSE.
        do_load(3);
        do_start();
        tick(2);
        start = 1'b1;
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        tick(1);
        start = 1'b0;
        tick(8);
        chk("start+pause count", int'(count), 1);
        $display("[TB] start+pause priority done");

        // Load aborts mid-run at count 6.
        do_load(9);
        do_start();
        tick(12);
        chk("mid-run count", int'(count), 6);
        do_load(8'h80);
        chk("abort load count", int'(count), 128);
        chk("abort load done", int'(done), 0);
        tick(10);
        chk("aborted holds", int'(count), 128);
        $display("[TB] load abort done");

        // Reset mid-run at count 6.
        do_load(9);
        do_start();
        tick(12);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid reset count", int'(count), 0);
        chk("mid reset busy", int'(busy), 0);
        tick(5);
        $display("[TB] mid-run reset done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
